// File: rtl/counter_pkg.sv
// Shared types and constants for multi_mode_counter.
// Define MULTI_MODE_COUNTER_SAT_EN to let the sat input select saturation; otherwise the counter always wraps.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

`ifdef MULTI_MODE_COUNTER_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

endpackage

// File: rtl/counter_nxt.sv
// Combinational next-count and boundary-event logic for multi_mode_counter.
// Saturation is honoured only when MULTI_MODE_COUNTER_SAT_EN is defined (see counter_pkg::SAT_EN).
module counter_nxt
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  lim_i,
    input  logic              m_i,
    input  logic              sat_i,
    output logic [WIDTH-1:0]  count_nxt_o,
    output logic              boundary_o
);

    localparam int XW = WIDTH + 1;

    logic [XW-1:0] cnt_x;
    logic [XW-1:0] lim_x;
    logic [XW-1:0] lim_p1;
    logic [XW-1:0] step_x;
    logic [XW-1:0] up_sum;
    logic [XW-1:0] up_wrap;
    logic [XW-1:0] dn_diff;
    logic [XW-1:0] dn_wrap;
    logic          sat_eff;

    assign cnt_x   = {1'b0, count_i};
    assign lim_x   = {1'b0, lim_i};
    assign step_x  = {{(XW-STEP_W){1'b0}}, step_i};
    assign lim_p1  = lim_x + XW'(1);
    assign up_sum  = cnt_x + step_x;
    assign dn_diff = cnt_x - step_x;

    // Wrapping is modular over [0, lim]: the overshoot past lim re-enters at 0,
    // and the undershoot below 0 re-enters at lim.
    assign up_wrap = up_sum - lim_p1;
    assign dn_wrap = lim_p1 + dn_diff;

    assign sat_eff = sat_i & SAT_EN;

    always_comb begin
        count_nxt_o = count_i;
        boundary_o  = 1'b0;
        if (step_i != '0) begin
            case (m_i)
                DIR_UP: begin
                    if (up_sum > lim_x) begin
                        if (sat_eff) begin
                            if (count_i != lim_i) begin
                                count_nxt_o = lim_i;
                                boundary_o  = 1'b1;
                            end
                        end else begin
                            // Overshoot larger than the range (count above lim after a load) lands on 0.
                            count_nxt_o = (up_wrap > lim_x) ? '0 : up_wrap[WIDTH-1:0];
                            boundary_o  = 1'b1;
                        end
                    end else begin
                        count_nxt_o = up_sum[WIDTH-1:0];
                    end
                end
                DIR_DOWN: begin
                    // Borrow out of the subtraction means count < step.
                    if (dn_diff[WIDTH]) begin
                        if (sat_eff) begin
                            if (count_i != '0) begin
                                count_nxt_o = '0;
                                boundary_o  = 1'b1;
                            end
                        end else begin
                            count_nxt_o = dn_wrap[WIDTH] ? lim_i : dn_wrap[WIDTH-1:0];
                            boundary_o  = 1'b1;
                        end
                    end else begin
                        count_nxt_o = dn_diff[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multi_mode_counter.sv
// Up/down counter over [0, lim] with wrap or saturate, terminal-count pulse and oneshot stop.
// Saturation support is compiled in with MULTI_MODE_COUNTER_SAT_EN; the default build always wraps.
module multi_mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              m,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lim,
    input  logic              oneshot,
    input  logic              sat,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              done
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             done_q;
    logic             boundary;

    counter_nxt #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_nxt (
        .count_i     (count_q),
        .step_i      (step),
        .lim_i       (lim),
        .m_i         (m),
        .sat_i       (sat),
        .count_nxt_o (count_d),
        .boundary_o  (boundary)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (load) begin
                count_q <= din;
                state_q <= RUN;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (en) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (en) begin
                            count_q <= count_d;
                            if (boundary) begin
                                tc_q <= 1'b1;
                                if (oneshot) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    DONE: ;
                    default: begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed testbench for multi_mode_counter (WIDTH=8, STEP_W=4).
// Expectations for the saturate vector follow MULTI_MODE_COUNTER_SAT_EN as seen by this file.
module tb_multi_mode_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       m;
    logic       load;
    logic [7:0] din;
    logic [3:0] step;
    logic [7:0] lim;
    logic       oneshot;
    logic       sat;
    logic [7:0] count;
    logic       tc;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    multi_mode_counter #(
        .WIDTH  (8),
        .STEP_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .m       (m),
        .load    (load),
        .din     (din),
        .step    (step),
        .lim     (lim),
        .oneshot (oneshot),
        .sat     (sat),
        .count   (count),
        .tc      (tc),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        $display("[%0t] %s observed=%0d expected=%0d", $time, tag, obs, exp);
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int t, input int d);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".tc"},    int'(tc),    t);
        chk({tag, ".done"},  int'(done),  d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; m = 1'b0; load = 1'b0; din = 8'd0;
        step = 4'd0; lim = 8'd255; oneshot = 1'b0; sat = 1'b0;
        #2;
        chk_all("reset", 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("idle_en0", 0, 0, 0);

        // Load
        din = 8'd100; load = 1'b1;
        tick();
        load = 1'b0;
        chk_all("load100", 100, 0, 0);

        // Up wrap
        din = 8'd250; load = 1'b1; lim = 8'd255; step = 4'd3; m = 1'b0; sat = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        chk("upwrap.load", int'(count), 250);
        tick();
        chk_all("upwrap.1", 253, 0, 0);
        tick();
        chk_all("upwrap.2", 0, 1, 0);
        tick();
        chk_all("upwrap.3", 3, 0, 0);

        // step=0 holds, no tc
        step = 4'd0;
        tick();
        chk_all("step0", 3, 0, 0);

        // en=0 holds
        step = 4'd3; en = 1'b0;
        tick();
        chk_all("en0", 3, 0, 0);

        // Down wrap, load wins over en
        din = 8'd5; load = 1'b1; lim = 8'd200; step = 4'd2; m = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        chk("dnwrap.load", int'(count), 5);
        tick();
        chk_all("dnwrap.1", 3, 0, 0);
        tick();
        chk_all("dnwrap.2", 1, 0, 0);
        tick();
        chk_all("dnwrap.3", 200, 1, 0);
        tick();
        chk_all("dnwrap.4", 198, 0, 0);

        // Saturate request
        din = 8'd254; load = 1'b1; lim = 8'd255; step = 4'd4; m = 1'b0; sat = 1'b1;
        tick();
        load = 1'b0;
        chk("sat.load", int'(count), 254);
        tick();
`ifdef MULTI_MODE_COUNTER_SAT_EN
        chk_all("sat.1", 255, 1, 0);
        tick();
        chk_all("sat.2", 255, 0, 0);
`else
        chk_all("sat.1", 2, 1, 0);
        tick();
        chk_all("sat.2", 6, 0, 0);
`endif
        sat = 1'b0;

        // Oneshot
        din = 8'd0; load = 1'b1; lim = 8'd3; step = 4'd1; m = 1'b0; oneshot = 1'b1;
        tick();
        load = 1'b0;
        chk_all("os.load", 0, 0, 0);
        tick();
        chk_all("os.1", 1, 0, 0);
        tick();
        chk_all("os.2", 2, 0, 0);
        tick();
        chk_all("os.3", 3, 0, 0);
        tick();
        chk_all("os.4", 0, 1, 1);
        tick();
        chk_all("os.frozen", 0, 0, 1);
        din = 8'd7; load = 1'b1;
        tick();
        load = 1'b0; oneshot = 1'b0; en = 1'b0;
        chk_all("os.reload", 7, 0, 0);

        // Async reset mid-count
        din = 8'd10; load = 1'b1; lim = 8'd255; step = 4'd1; m = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk_all("pre_rst", 11, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0);
        tick();
        chk_all("rst_held", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_all("idle_to_run", 0, 0, 0);
        tick();
        chk_all("resume.1", 1, 0, 0);
        tick();
        chk_all("resume.2", 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
